// File: rtl/io_in_i2f.sv
// Converts signed fixed-point samples to packed float words, one normalisation shift per cycle, then queues them for the processor.
// Latency is k+2 edges from accept to FIFO. s_ready drops while converting, and a full FIFO holds the converter in CONV until a read frees a slot.
module io_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    // The caller only asserts push or pop when they are legal.
    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
endmodule

module io_in_i2f #(
    parameter int NBMANT    = 16,
    parameter int NBEXPO    = 6,
    parameter int NBIN      = 16,
    parameter int FRAC      = 0,
    parameter int FDEPTH    = 4,
    parameter int NUIOIN    = 8,
    parameter int PORT_ADDR = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NBIN-1:0]            s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic                       req_in,
    input  logic [$clog2(NUIOIN)-1:0]  addr_in,
    output logic [NBMANT+NBEXPO:0]     io_in,
    output logic                       empty,
    output logic                       rd_err
);
    localparam int AW   = $clog2(NUIOIN);
    localparam int MAGW = (NBIN > NBMANT) ? NBIN : NBMANT;
    localparam int EMIN = -FRAC - (NBMANT - 1);
    localparam int EMAX = NBIN - NBMANT - FRAC;
    localparam int ELO  = -(2 ** (NBEXPO - 1));
    localparam int EHI  = (2 ** (NBEXPO - 1)) - 1;
    localparam logic [NBEXPO-1:0] EXP_INIT = NBEXPO'(-FRAC);

    if (EMIN < ELO || EMAX > EHI) begin : g_bad_expo
        $error("io_in_i2f: exponent range does not fit in NBEXPO bits");
    end
    if (FDEPTH < 2 || (FDEPTH & (FDEPTH - 1)) != 0) begin : g_bad_depth
        $error("io_in_i2f: FDEPTH must be a power of two >= 2");
    end

    typedef struct packed {
        logic              sign;
        logic [NBEXPO-1:0] expo;
        logic [NBMANT-1:0] mant;
    } fword_t;

    typedef enum logic {IDLE, CONV} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              sign_r;
    logic [MAGW-1:0]   mag_r;
    logic [NBEXPO-1:0] exp_r;
    logic [NBIN-1:0]   s_abs;
    logic              mag_zero;
    logic              mag_big;
    logic              mag_low;
    logic              conv_done;
    logic              conv_en;
    logic              hit;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;
    fword_t            push_word;
    fword_t            head;
    fword_t            last_rd;

    // Unsigned NBIN-bit negate: the most negative input maps to 2^(NBIN-1).
    assign s_abs     = s_data[NBIN-1] ? (~s_data + 1'b1) : s_data;
    assign mag_zero  = (mag_r == '0);
    assign mag_big   = |(mag_r >> NBMANT);
    assign mag_low   = ~mag_r[NBMANT-1];
    assign conv_done = mag_zero | (~mag_big & ~mag_low);

    assign hit  = req_in && (addr_in == AW'(PORT_ADDR));
    assign pop  = hit & ~fifo_empty;
    assign push = conv_en & conv_done & (~fifo_full | pop);

    always_comb begin
        push_word = '0;
        if (!mag_zero) begin
            push_word.sign = sign_r;
            push_word.expo = exp_r;
            push_word.mant = mag_r[NBMANT-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (s_valid) state_nxt = CONV;
            CONV:    if (push)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state == IDLE);
        conv_en = (state == CONV);
    end

    // A stalled, already-normalised value needs no register update, so it simply holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_r <= 1'b0;
            mag_r  <= '0;
            exp_r  <= '0;
        end else if (s_ready && s_valid) begin
            sign_r <= s_data[NBIN-1];
            mag_r  <= MAGW'(s_abs);
            exp_r  <= EXP_INIT;
        end else if (conv_en && !mag_zero) begin
            if (mag_big) begin
                mag_r <= mag_r >> 1;
                exp_r <= exp_r + 1'b1;
            end else if (mag_low) begin
                mag_r <= mag_r << 1;
                exp_r <= exp_r - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_rd <= '0;
            rd_err  <= 1'b0;
        end else begin
            rd_err <= hit & fifo_empty;
            if (pop) last_rd <= head;
        end
    end

    io_fifo #(
        .W     ($bits(fword_t)),
        .DEPTH (FDEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_word),
        .pop      (pop),
        .head_dat (head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign empty = fifo_empty;
    assign io_in = fifo_empty ? last_rd : head;
endmodule

// File: tb/tb_io_in_i2f.sv
// Directed bench for io_in_i2f: stimulus queues expected words, and negedge monitors compare them on every pop.
module tb_io_in_i2f;
    localparam int W = 23;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  s_data;
    logic         s_valid, s_ready, req_in, empty, rd_err;
    logic [2:0]   addr_in;
    logic [W-1:0] io_in;
    logic         s_valid4, s_ready4, req4, empty4, rd_err4;
    logic [W-1:0] io_in4;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] q[$];
    logic [W-1:0] q4[$];
    logic [W-1:0] exp_m, exp_m4;
    int n, low;

    always #5 clk = ~clk;

    io_in_i2f #(.FRAC(0)) u_dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .req_in(req_in), .addr_in(addr_in), .io_in(io_in), .empty(empty), .rd_err(rd_err)
    );

    io_in_i2f #(.FRAC(4)) u_frac4 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid4), .s_ready(s_ready4),
        .req_in(req4), .addr_in(addr_in), .io_in(io_in4), .empty(empty4), .rd_err(rd_err4)
    );

    always @(negedge clk) begin
        if (!rst && req_in && addr_in == 3'd0 && !empty) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected actual=%h required=none", io_in);
            end else begin
                exp_m = q.pop_front();
                if (io_in !== exp_m) begin
                    errors++;
                    $display("FAIL pop_word actual=%h required=%h", io_in, exp_m);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && req4 && addr_in == 3'd0 && !empty4) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL pop4_unexpected actual=%h required=none", io_in4);
            end else begin
                exp_m4 = q4.pop_front();
                if (io_in4 !== exp_m4) begin
                    errors++;
                    $display("FAIL pop4_word actual=%h required=%h", io_in4, exp_m4);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "simulation timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic [W-1:0] e);
        int t = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && t < 64) begin
            tick();
            t++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=%0d required=<64", t);
            s_valid = 1'b0;
        end else begin
            q.push_back(e);
            tick();
            s_valid = 1'b0;
        end
    endtask

    // Counts edges from the accept edge (inclusive) until the word reaches the FIFO.
    task automatic wait_push(output int edges, output int lows);
        edges = 1;
        lows  = 0;
        while (empty && edges < 100) begin
            if (!s_ready) lows++;
            tick();
            edges++;
        end
    endtask

    task automatic read();
        req_in  = 1'b1;
        addr_in = 3'd0;
        tick();
        req_in  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s_data = '0; s_valid = 1'b0; s_valid4 = 1'b0;
        req_in = 1'b0; req4 = 1'b0; addr_in = '0;
        repeat (3) tick();
        chk("rst_s_ready", W'(s_ready), 1);
        chk("rst_empty",   W'(empty), 1);
        chk("rst_rd_err",  W'(rd_err), 0);
        chk("rst_io_in",   io_in, 0);
        rst = 1'b0;
        tick();

        // Smallest positive value needs the full 15 left shifts.
        send(16'h0001, 23'h318000);
        wait_push(n, low);
        chk("lat_one", W'(n), 17);
        chk("ready_low_one", W'(low), 16);
        read();
        chk("one_empty_after", W'(empty), 1);
        chk("one_last_rd", io_in, 23'h318000);

        send(16'h8000, 23'h408000);
        wait_push(n, low);
        chk("lat_minmax", W'(n), 2);
        read();

        send(16'h0000, 23'h000000);
        wait_push(n, low);
        chk("lat_zero", W'(n), 2);
        read();

        send(16'hFFFD, 23'h72C000);
        wait_push(n, low);
        chk("lat_neg3", W'(n), 16);
        read();

        // Fill the FIFO, then stall a fifth sample behind it.
        send(16'h4000, 23'h3F8000);
        send(16'h7FFF, 23'h3FFFFE);
        send(16'hFFFF, 23'h718000);
        send(16'h1234, 23'h3D91A0);
        repeat (6) tick();
        chk("fill_not_empty", W'(empty), 0);
        send(16'h0100, 23'h398000);
        repeat (12) tick();
        chk("stall_ready", W'(s_ready), 0);
        chk("stall_head", io_in, 23'h3F8000);
        read();
        chk("stall_release", W'(s_ready), 1);
        repeat (4) read();
        chk("drain_empty", W'(empty), 1);

        // Reads addressed elsewhere are ignored.
        send(16'h4000, 23'h3F8000);
        repeat (4) tick();
        req_in = 1'b1; addr_in = 3'd1;
        tick();
        req_in = 1'b0; addr_in = 3'd0;
        chk("other_addr_empty", W'(empty), 0);
        chk("other_addr_io", io_in, 23'h3F8000);
        chk("other_addr_err", W'(rd_err), 0);
        read();
        chk("after_read_empty", W'(empty), 1);

        read();
        chk("empty_rd_err", W'(rd_err), 1);
        chk("empty_hold_io", io_in, 23'h3F8000);
        tick();
        chk("rd_err_pulse", W'(rd_err), 0);

        // Reset mid-conversion with a word already queued.
        send(16'h4000, 23'h3F8000);
        repeat (4) tick();
        send(16'h0001, 23'h318000);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_ready", W'(s_ready), 1);
        chk("mid_rst_empty", W'(empty), 1);
        chk("mid_rst_io", io_in, 0);
        rst = 1'b0;
        q.delete();
        tick();
        send(16'hFFFD, 23'h72C000);
        wait_push(n, low);
        chk("post_rst_lat", W'(n), 16);
        read();

        // FRAC=4 instance: 16 is 1.0, which normalises to 0x8000 * 2^-15.
        s_data = 16'h0010;
        chk("f4_ready", W'(s_ready4), 1);
        s_valid4 = 1'b1;
        q4.push_back(23'h318000);
        tick();
        s_valid4 = 1'b0;
        repeat (14) tick();
        chk("f4_not_empty", W'(empty4), 0);
        req4 = 1'b1; addr_in = 3'd0;
        tick();
        req4 = 1'b0;
        chk("f4_empty_after", W'(empty4), 1);

        tick();
        chk("sb_left", W'(q.size()), 0);
        chk("sb4_left", W'(q4.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
